tx_phyretrain: RTL and testbench

Transmit-side PHYRETRAIN handshake engine for the LTSM. It is enabled by the LTSM together with its receive-side counterpart. It latches the local retrain cause into a one-hot retrain encoding and sends PHYRETRAIN_START_REQ over the sideband, carrying that encoding. It then waits for the partner's PHYRETRAIN_START_RESP and reports completion or timeout to the LTSM. Its encoding and valid outputs feed the receive-side PHYRETRAIN block, which uses them for state resolution and for sideband arbitration.

---
 rtl/tx_phyretrain.sv | 85 ++++++++
 tb/tb_tx_phyretrain.sv | 134 +++++++++++++
 2 files changed

// File: rtl/tx_phyretrain.sv
// tx_phyretrain: transmit-side PHYRETRAIN handshake (latch cause, send START_REQ, await START_RESP or timeout)
// Ports: i_clk/i_rst_n clock and async active-low reset; i_phyretrain_en LTSM enable;
//   i_txselfcal_req/i_speedidle_req/i_repair_req local retrain causes; i_rx_msg_valid/i_decoded_SB_msg partner message;
//   i_SB_Busy/i_falling_edge_busy sideband status; i_rx_valid rx-side block presenting;
//   o_encoded_SB_msg_tx/o_valid_tx message to sideband; o_local_retrain_encoding one-hot cause;
//   o_phyretrain_end_tx handshake done; o_timeout no response in time.
module tx_phyretrain #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_phyretrain_en,
  input  logic                    i_txselfcal_req,
  input  logic                    i_speedidle_req,
  input  logic                    i_repair_req,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_SB_Busy,
  input  logic                    i_falling_edge_busy,
  input  logic                    i_rx_valid,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx,
  output logic [2:0]              o_local_retrain_encoding,
  output logic                    o_valid_tx,
  output logic                    o_phyretrain_end_tx,
  output logic                    o_timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, SEND_REQ, WAIT_RESP, TEST_FINISHED, TIMEOUT} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic valid_q, pending, resp_seen;
  logic entry, active, resp_now, cnt_max, free, fall;
  assign entry    = state == IDLE && i_phyretrain_en;
  assign active   = state == SEND_REQ || state == WAIT_RESP;
  assign resp_now = i_rx_msg_valid && i_decoded_SB_msg == SB_MSG_WIDTH'(2);
  assign cnt_max  = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign free     = !i_SB_Busy && !i_rx_valid;
  assign fall     = valid_q && !o_valid_tx;
  always_comb begin
    nxt = state;
    if (!i_phyretrain_en) nxt = IDLE;
    else if (state == IDLE) nxt = SEND_REQ;
    else if (state == SEND_REQ) nxt = cnt_max ? TIMEOUT : fall ? WAIT_RESP : SEND_REQ;
    else if (state == WAIT_RESP) nxt = (resp_seen || resp_now) ? TEST_FINISHED : cnt_max ? TIMEOUT : WAIT_RESP;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt                      <= '0;
      valid_q                  <= 1'b0;
      pending                  <= 1'b0;
      resp_seen                <= 1'b0;
      o_encoded_SB_msg_tx      <= '0;
      o_local_retrain_encoding <= 3'b000;
      o_valid_tx               <= 1'b0;
      o_phyretrain_end_tx      <= 1'b0;
      o_timeout                <= 1'b0;
    end else begin
      valid_q             <= o_valid_tx;
      resp_seen           <= active && i_phyretrain_en && (resp_seen || resp_now);
      cnt                 <= entry ? '0 : (active && !cnt_max) ? cnt + 1'b1 : cnt;
      o_phyretrain_end_tx <= i_phyretrain_en && (o_phyretrain_end_tx || (state == WAIT_RESP && nxt == TEST_FINISHED));
      o_timeout           <= i_phyretrain_en && (o_timeout || nxt == TIMEOUT);
      o_encoded_SB_msg_tx <= !i_phyretrain_en ? '0 : entry ? SB_MSG_WIDTH'(1) : o_encoded_SB_msg_tx;
      if (entry)
        o_local_retrain_encoding <= i_speedidle_req ? 3'b010 : i_repair_req ? 3'b100 :
                                    {2'b00, i_txselfcal_req | ~(i_speedidle_req | i_repair_req | i_txselfcal_req)};
      if (!i_phyretrain_en) begin
        o_valid_tx <= 1'b0;
        pending    <= 1'b0;
      end else if (entry) begin
        o_valid_tx <= !i_falling_edge_busy && free;
        pending    <= i_falling_edge_busy || !free;
      end else if (i_falling_edge_busy) begin
        o_valid_tx <= 1'b0;
      end else if (pending && free) begin
        o_valid_tx <= 1'b1;
        pending    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tx_phyretrain.sv
// tb_tx_phyretrain: directed table-driven bench for tx_phyretrain
module tb_tx_phyretrain;
  logic clk = 0, rst_n = 0, en = 0, selfcal = 0, speed = 0, repair = 0;
  logic rmv = 0, busy = 0, feb = 0, rxv = 0;
  logic [3:0] rmsg = 0, msg;
  logic [2:0] enc;
  logic valid, end_tx, to;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  tx_phyretrain #(.SB_MSG_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_phyretrain_en(en),
    .i_txselfcal_req(selfcal), .i_speedidle_req(speed), .i_repair_req(repair),
    .i_rx_msg_valid(rmv), .i_decoded_SB_msg(rmsg), .i_SB_Busy(busy),
    .i_falling_edge_busy(feb), .i_rx_valid(rxv),
    .o_encoded_SB_msg_tx(msg), .o_local_retrain_encoding(enc), .o_valid_tx(valid),
    .o_phyretrain_end_tx(end_tx), .o_timeout(to));
  typedef struct {
    int n;
    bit en;
    bit [2:0] c;
    bit rmv;
    bit [3:0] rm;
    bit busy, feb, rxv;
    bit [10:0] exp;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(int n, bit en_i, bit [2:0] c, bit rmv_i, bit [3:0] rm, bit busy_i, bit feb_i, bit rxv_i,
                              bit [3:0] em, bit [2:0] ee, bit ev, bit eend, bit eto);
    vec_t v;
    v.n = n; v.en = en_i; v.c = c; v.rmv = rmv_i; v.rm = rm;
    v.busy = busy_i; v.feb = feb_i; v.rxv = rxv_i;
    v.exp = {em, ee, ev, eend, eto};
    tbl.push_back(v);
  endfunction
  task automatic chk(string name, logic [10:0] exp);
    logic [10:0] act;
    act = {msg, enc, valid, end_tx, to};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: msg/enc/valid/end/timeout got %b required %b", name, act, exp);
    end
  endtask
  initial begin
    // cause = {repair, speed, selfcal}; expected = msg, enc, valid, end, timeout
    add(1, 1, 3'b100, 0, 0, 0, 0, 0, 1, 3'b100, 1, 0, 0);
    add(4, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b100, 1, 0, 0);
    add(1, 1, 3'b000, 0, 0, 0, 1, 0, 1, 3'b100, 0, 0, 0);
    add(1, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b100, 0, 0, 0);
    add(3, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b100, 0, 0, 0);
    add(1, 1, 3'b000, 1, 1, 0, 0, 0, 1, 3'b100, 0, 0, 0);
    add(4, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b100, 0, 0, 0);
    add(1, 1, 3'b000, 1, 2, 0, 0, 0, 1, 3'b100, 0, 1, 0);
    add(1, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b100, 0, 1, 0);
    add(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0);
    add(1, 0, 3'b000, 1, 2, 0, 0, 0, 0, 3'b100, 0, 0, 0);
    add(1, 1, 3'b111, 0, 0, 0, 0, 0, 1, 3'b010, 1, 0, 0);
    add(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0);
    add(1, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b001, 1, 0, 0);
    add(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0);
    add(1, 1, 3'b101, 0, 0, 0, 0, 0, 1, 3'b100, 1, 0, 0);
    add(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0);
    add(1, 1, 3'b010, 0, 0, 0, 0, 1, 1, 3'b010, 0, 0, 0);
    add(2, 1, 3'b000, 0, 0, 0, 0, 1, 1, 3'b010, 0, 0, 0);
    add(1, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b010, 1, 0, 0);
    add(1, 1, 3'b000, 0, 0, 1, 0, 0, 1, 3'b010, 1, 0, 0);
    add(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0);
    add(1, 1, 3'b001, 0, 0, 1, 0, 0, 1, 3'b001, 0, 0, 0);
    add(1, 1, 3'b000, 0, 0, 1, 0, 0, 1, 3'b001, 0, 0, 0);
    add(1, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b001, 1, 0, 0);
    add(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0);
    add(1, 1, 3'b100, 0, 0, 0, 0, 1, 1, 3'b100, 0, 0, 0);
    add(1, 1, 3'b000, 0, 0, 0, 1, 0, 1, 3'b100, 0, 0, 0);
    add(1, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b100, 1, 0, 0);
    add(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0);
    add(1, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b001, 1, 0, 0);
    add(1, 1, 3'b000, 1, 2, 0, 0, 0, 1, 3'b001, 1, 0, 0);
    add(1, 1, 3'b000, 0, 0, 0, 1, 0, 1, 3'b001, 0, 0, 0);
    add(1, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b001, 0, 0, 0);
    add(1, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b001, 0, 1, 0);
    add(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0);
    add(1, 1, 3'b010, 0, 0, 0, 0, 0, 1, 3'b010, 1, 0, 0);
    add(1, 1, 3'b000, 0, 0, 0, 1, 0, 1, 3'b010, 0, 0, 0);
    add(2, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0);
    add(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0);
    add(2, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0);
    add(1, 1, 3'b100, 0, 0, 0, 0, 0, 1, 3'b100, 1, 0, 0);
    add(2, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b100, 1, 0, 0);
    add(1, 1, 3'b000, 0, 0, 0, 1, 0, 1, 3'b100, 0, 0, 0);
    add(12, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b100, 0, 0, 0);
    add(1, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b100, 0, 0, 1);
    add(2, 1, 3'b000, 1, 2, 0, 0, 0, 1, 3'b100, 0, 0, 1);
    add(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0);
    add(1, 1, 3'b010, 0, 0, 0, 0, 0, 1, 3'b010, 1, 0, 0);
    add(1, 1, 3'b000, 0, 0, 0, 1, 0, 1, 3'b010, 0, 0, 0);
    add(14, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0);
    add(1, 1, 3'b000, 1, 2, 0, 0, 0, 1, 3'b010, 0, 1, 0);
    add(1, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b010, 0, 1, 0);
    add(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0);
    #12;
    chk("reset", 11'd0);
    @(negedge clk) rst_n = 1;
    foreach (tbl[i])
      for (int k = 0; k < tbl[i].n; k++) begin
        @(negedge clk);
        en = tbl[i].en;
        {repair, speed, selfcal} = tbl[i].c;
        rmv = tbl[i].rmv; rmsg = tbl[i].rm;
        busy = tbl[i].busy; feb = tbl[i].feb; rxv = tbl[i].rxv;
        @(posedge clk); #1;
        chk($sformatf("vec%0d.%0d", i, k), tbl[i].exp);
      end
    @(negedge clk);
    en = 1; {repair, speed, selfcal} = 3'b100;
    rmv = 0; rmsg = 0; busy = 0; feb = 0; rxv = 0;
    @(posedge clk); #1;
    chk("arst_entry", {4'd1, 3'b100, 3'b100});
    @(negedge clk) rst_n = 0;
    #1 chk("arst_immediate", 11'd0);
    @(posedge clk); #1;
    chk("arst_hold", 11'd0);
    @(negedge clk);
    rst_n = 1; en = 0;
    @(posedge clk); #1;
    chk("arst_idle", 11'd0);
    @(negedge clk);
    en = 1; {repair, speed, selfcal} = 3'b010;
    @(posedge clk); #1;
    chk("arst_reentry", {4'd1, 3'b010, 3'b100});
    @(negedge clk) en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
